// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: states, opcodes, funct codes,
// ALU operations, datapath mux selects and the per-state control word.
package mc_pkg;

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRd    = 4'd4,
    StMemWb    = 4'd5,
    StMemWr    = 4'd6,
    StExec     = 4'd7,
    StSraExec  = 4'd8,
    StAluWb    = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StBranch   = 4'd12,
    StJump     = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSra = 6'b000011;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;
  localparam logic [2:0] AluSra = 3'b011;

  localparam logic [1:0] SrcAPc = 2'b00;
  localparam logic [1:0] SrcAA  = 2'b01;
  localparam logic [1:0] SrcAB  = 2'b10;

  localparam logic [2:0] SrcBB      = 3'b000;
  localparam logic [2:0] SrcBFour   = 3'b001;
  localparam logic [2:0] SrcBImm    = 3'b010;
  localparam logic [2:0] SrcBImmSh  = 3'b011;
  localparam logic [2:0] SrcBShamt  = 3'b100;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       branch;
    logic       instr_done;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
  } ctl_t;

  // Control word for a state; exec_alu_ctl is only consulted in StExec.
  function automatic ctl_t ctl_for(state_e st, logic [2:0] exec_alu_ctl);
    ctl_t c;
    c           = '0;
    c.alu_src_a = SrcAPc;
    c.alu_src_b = SrcBB;
    c.alu_ctl   = AluAnd;
    c.pc_src    = PcSrcAlu;
    case (st)
      StFetch: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_a = SrcAPc;
        c.alu_src_b = SrcBFour;
        c.alu_ctl   = AluAdd;
      end
      StDecode: begin
        c.alu_src_a = SrcAPc;
        c.alu_src_b = SrcBImmSh;
        c.alu_ctl   = AluAdd;
      end
      StMemAdr, StAddiExec: begin
        c.alu_src_a = SrcAA;
        c.alu_src_b = SrcBImm;
        c.alu_ctl   = AluAdd;
      end
      StMemRd: c.i_or_d = 1'b1;
      StMemWb: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StMemWr: begin
        c.i_or_d     = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StExec: begin
        c.alu_src_a = SrcAA;
        c.alu_src_b = SrcBB;
        c.alu_ctl   = exec_alu_ctl;
      end
      StSraExec: begin
        c.alu_src_a = SrcAB;
        c.alu_src_b = SrcBShamt;
        c.alu_ctl   = AluSra;
      end
      StAluWb: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StAddiWb: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StBranch: begin
        c.alu_src_a  = SrcAA;
        c.alu_src_b  = SrcBB;
        c.alu_ctl    = AluSub;
        c.branch     = 1'b1;
        c.pc_src     = PcSrcAluOut;
        c.instr_done = 1'b1;
      end
      StJump: begin
        c.pc_src     = PcSrcJump;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
interface mc_control_fsm_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_en;
  logic        ir_write;
  logic        mem_write;
  logic        i_or_d;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic [1:0]  alu_src_a;
  logic [2:0]  alu_src_b;
  logic [2:0]  alu_ctl;
  logic [1:0]  pc_src;
  logic        instr_done;
  logic        illegal;
  logic [31:0] instr_count;
  logic [3:0]  state;

  modport master (
    input  opcode, funct, zero,
    output pc_en, ir_write, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_ctl, pc_src, instr_done, illegal, instr_count, state
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_en, ir_write, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_ctl, pc_src, instr_done, illegal, instr_count, state
  );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation decoder; purely combinational so the single-cycle core can reuse it.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl,
  output logic       valid
);

  always_comb begin
    alu_ctl = AluAdd;
    valid   = 1'b1;
    case (funct)
      FnAdd:   alu_ctl = AluAdd;
      FnSub:   alu_ctl = AluSub;
      FnAnd:   alu_ctl = AluAnd;
      FnOr:    alu_ctl = AluOr;
      FnSlt:   alu_ctl = AluSlt;
      FnSra:   alu_ctl = AluSra;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back, drives registered
// datapath controls and counts retired instructions.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mc_control_fsm_if.master bus
);

  state_e      state_q, state_d;
  ctl_t        ctl_q;
  logic [31:0] instr_count_q;
  logic        is_load_q;
  logic [2:0]  dec_alu_ctl;
  logic        dec_valid;
  logic        decode_illegal;

  alu_decoder u_alu_decoder (
    .funct   (bus.funct),
    .alu_ctl (dec_alu_ctl),
    .valid   (dec_valid)
  );

  always_comb begin
    state_d        = StFetch;
    decode_illegal = 1'b0;
    case (state_q)
      StReset: state_d = StFetch;
      StFetch: state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype: begin
            if (!dec_valid)               decode_illegal = 1'b1;
            else if (bus.funct == FnSra)  state_d = StSraExec;
            else                          state_d = StExec;
          end
          OpBeq:   state_d = StBranch;
          OpAddi:  state_d = StAddiExec;
          OpJ:     state_d = StJump;
          default: decode_illegal = 1'b1;
        endcase
      end
      StMemAdr:             state_d = is_load_q ? StMemRd : StMemWr;
      StMemRd:              state_d = StMemWb;
      StExec, StSraExec:    state_d = StAluWb;
      StAddiExec:           state_d = StAddiWb;
      default:              state_d = StFetch;
    endcase
  end

  // Outputs are registered: the control word for the next state is loaded with the state itself,
  // and the EXEC ALU operation is decoded from funct while still in DECODE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StReset;
      ctl_q         <= '0;
      instr_count_q <= '0;
      is_load_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_for(state_d, dec_alu_ctl);
      if (ctl_q.instr_done) instr_count_q <= instr_count_q + 32'd1;
      if (state_q == StDecode) is_load_q <= (bus.opcode == OpLw);
    end
  end

  assign bus.pc_en       = ctl_q.pc_write | (ctl_q.branch & bus.zero);
  assign bus.ir_write    = ctl_q.ir_write;
  assign bus.mem_write   = ctl_q.mem_write;
  assign bus.i_or_d      = ctl_q.i_or_d;
  assign bus.reg_write   = ctl_q.reg_write;
  assign bus.reg_dst     = ctl_q.reg_dst;
  assign bus.mem_to_reg  = ctl_q.mem_to_reg;
  assign bus.alu_src_a   = ctl_q.alu_src_a;
  assign bus.alu_src_b   = ctl_q.alu_src_b;
  assign bus.alu_ctl     = ctl_q.alu_ctl;
  assign bus.pc_src      = ctl_q.pc_src;
  assign bus.instr_done  = ctl_q.instr_done;
  assign bus.illegal     = decode_illegal;
  assign bus.instr_count = instr_count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized instruction stream checked every cycle against a per-instruction cycle-table model.
module tb_mc_control_fsm;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {KLw, KSw, KRt, KSra, KAddi, KBeq, KJ, KIll} kind_e;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        chk_en   = 1'b0;
  logic [18:0] exp_ctl;
  logic [3:0]  exp_state;
  logic [31:0] exp_count;
  logic [31:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic [18:0] pack_dut();
    return {bus.pc_en, bus.ir_write, bus.mem_write, bus.i_or_d, bus.reg_write, bus.reg_dst,
            bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_ctl, bus.pc_src,
            bus.instr_done, bus.illegal};
  endfunction

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return KLw;
      6'b101011: return KSw;
      6'b000100: return KBeq;
      6'b001000: return KAddi;
      6'b000010: return KJ;
      6'b000000: begin
        if (fn == 6'b000011) return KSra;
        if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 || fn == 6'b100101 ||
            fn == 6'b101010) return KRt;
        return KIll;
      end
      default: return KIll;
    endcase
  endfunction

  function automatic int latency(input kind_e k);
    case (k)
      KLw:              return 5;
      KSw, KRt, KSra, KAddi: return 4;
      KBeq, KJ:         return 3;
      default:          return 2;
    endcase
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected state and outputs in cycle c (0 = FETCH) of an instruction of kind k.
  function automatic void model(input kind_e k, input int c, input logic [5:0] fn, input logic z,
                                output logic [3:0] st, output logic [18:0] ctl);
    logic pe, irw, mw, iod, rw, rd, m2r, done, ill;
    logic [1:0] a, ps;
    logic [2:0] b, alu;
    {pe, irw, mw, iod, rw, rd, m2r, done, ill} = '0;
    a = 2'b00; ps = 2'b00; b = 3'b000; alu = 3'b000;
    st = 4'd0;
    if (c == 0) begin
      st = 4'd1; irw = 1'b1; pe = 1'b1; b = 3'b001; alu = 3'b010;
    end else if (c == 1) begin
      st = 4'd2; b = 3'b011; alu = 3'b010; ill = (k == KIll);
    end else begin
      case (k)
        KLw, KSw: begin
          if (c == 2) begin st = StMemAdr; a = 2'b01; b = 3'b010; alu = 3'b010; end
          else if (k == KSw) begin st = StMemWr; iod = 1'b1; mw = 1'b1; done = 1'b1; end
          else if (c == 3) begin st = StMemRd; iod = 1'b1; end
          else begin st = StMemWb; m2r = 1'b1; rw = 1'b1; done = 1'b1; end
        end
        KRt, KSra: begin
          if (c == 3) begin st = StAluWb; rd = 1'b1; rw = 1'b1; done = 1'b1; end
          else if (k == KRt) begin st = StExec; a = 2'b01; b = 3'b000; alu = rtype_alu(fn); end
          else begin st = StSraExec; a = 2'b10; b = 3'b100; alu = 3'b011; end
        end
        KAddi: begin
          if (c == 2) begin st = StAddiExec; a = 2'b01; b = 3'b010; alu = 3'b010; end
          else begin st = StAddiWb; rw = 1'b1; done = 1'b1; end
        end
        KBeq: begin
          st = StBranch; a = 2'b01; alu = 3'b110; ps = 2'b01; done = 1'b1; pe = z;
        end
        KJ: begin
          st = StJump; ps = 2'b10; pe = 1'b1; done = 1'b1;
        end
        default: ;
      endcase
    end
    ctl = {pe, irw, mw, iod, rw, rd, m2r, a, b, alu, ps, done, ill};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", 32'(bus.state), 32'(exp_state));
      check("ctl", 32'(pack_dut()), 32'(exp_ctl));
      check("instr_count", bus.instr_count, exp_count);
    end
  end

  // Enters at posedge+1 of the FETCH cycle; returns at posedge+1 of the following cycle, or
  // stays in the last requested cycle when ncyc is shorter than the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int ncyc, input bit preload);
    kind_e k;
    int    lat;
    k   = classify(op, fn);
    lat = latency(k);
    if (ncyc < 0 || ncyc > lat) ncyc = lat;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 0) begin bus.opcode = op; bus.funct = fn; end
      if (c == 1 && preload) release dut.instr_count_q;
      bus.zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (c == 0 && preload) begin
        force dut.instr_count_q = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
      end
      model(k, c, fn, bus.zero, exp_state, exp_ctl);
      exp_count = m_count;
      chk_en    = 1'b1;
      if (exp_ctl[1]) m_count = m_count + 32'd1;
    end
    if (ncyc == lat) begin @(posedge clk); #1; end
  endtask

  task automatic reset_and_release();
    chk_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_ctl", 32'(pack_dut()), 32'd0);
    check("rst_count", bus.instr_count, 32'd0);
    m_count = 32'd0;
    @(posedge clk); #1;
    check("rst_hold_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_state", 32'(bus.state), 32'd0);
    @(posedge clk); #1;
    check("first_fetch", 32'(bus.state), 32'd1);
  endtask

  logic [5:0] rfn [5];
  logic [5:0] op, fn;
  int         r;

  initial begin
    rfn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst = 1'b1;
    bus.opcode = 6'd0;
    bus.funct  = 6'd0;
    bus.zero   = 1'b0;
    m_count    = 32'd0;
    #1;
    reset_and_release();

    run_instr(6'b100011, 6'd0, -1, -1, 1'b0);
    check("lw_count", bus.instr_count, 32'd1);
    run_instr(6'b000000, 6'b000011, -1, -1, 1'b0);
    check("sra_count", bus.instr_count, 32'd2);
    run_instr(6'b000100, 6'd0, 1, -1, 1'b0);
    run_instr(6'b000100, 6'd0, 0, -1, 1'b0);
    check("beq_count", bus.instr_count, 32'd4);
    run_instr(6'b111111, 6'd0, -1, -1, 1'b0);
    check("illegal_count", bus.instr_count, 32'd4);
    check("illegal_then_fetch", 32'(bus.state), 32'd1);

    // lw interrupted by reset while in MEMRD
    run_instr(6'b100011, 6'd0, -1, 4, 1'b0);
    #6;
    reset_and_release();

    run_instr(6'b000010, 6'd0, -1, -1, 1'b1);
    check("wrap_count", bus.instr_count, 32'd0);

    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      fn = 6'($urandom);
      case (r)
        0:       op = 6'b100011;
        1:       op = 6'b101011;
        2, 3:    begin op = 6'b000000; fn = rfn[$urandom_range(0, 4)]; end
        4:       begin op = 6'b000000; fn = 6'b000011; end
        5:       op = 6'b001000;
        6:       op = 6'b000100;
        7:       op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn, -1, -1, 1'b0);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
